// File: rtl/ecall_console_tx.sv
// ECALL putchar/halt service: character FIFO feeding a UART transmitter, with halt acknowledged only once drained.
// Define CONSOLE_PARITY_EN to append an even-parity bit between the data bits and the stop bit.
module ecall_console_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            putc_valid,
    input  logic [7:0]                      putc_char,
    output logic                            putc_ready,
    input  logic                            halt_req,
    output logic                            halt_done,
    output logic                            uart_tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              halt_pending_reg;
    logic              halt_done_reg;

    state_t            state_reg;
    logic [BAUD_W-1:0] baud_reg;
    logic [2:0]        bit_reg;
    logic [7:0]        data_reg;
    logic              tx_reg;

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              baud_last;
    logic [2:0]        bit_next;

    assign fifo_empty = (count_reg == '0);
    assign putc_ready = (count_reg != CNT_W'(FIFO_DEPTH)) && !halt_pending_reg;
    assign push       = putc_valid && putc_ready;
    assign baud_last  = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));
    assign bit_next   = bit_reg + 3'd1;
    // The head is popped either from IDLE or at the last cycle of a stop bit, so frames chain without a gap.
    assign pop        = !fifo_empty &&
                        ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_last));

    assign uart_tx    = tx_reg;
    assign busy       = !fifo_empty || (state_reg != ST_IDLE);
    assign halt_done  = halt_done_reg;
    assign fifo_count = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= putc_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            halt_pending_reg <= 1'b0;
            halt_done_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (halt_req) begin
                halt_pending_reg <= 1'b1;
            end
            if (halt_pending_reg && fifo_empty && (state_reg == ST_IDLE)) begin
                halt_done_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            data_reg  <= '0;
            tx_reg    <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    baud_reg <= '0;
                    if (pop) begin
                        data_reg  <= mem[rd_ptr_reg];
                        state_reg <= ST_START;
                        tx_reg    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_reg  <= '0;
                        bit_reg   <= '0;
                        state_reg <= ST_DATA;
                        tx_reg    <= data_reg[0];
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_reg <= '0;
                        if (bit_reg == 3'd7) begin
`ifdef CONSOLE_PARITY_EN
                            state_reg <= ST_PARITY;
                            tx_reg    <= ^data_reg;
`else
                            state_reg <= ST_STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_reg <= bit_next;
                            tx_reg  <= data_reg[bit_next];
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_last) begin
                        baud_reg  <= '0;
                        state_reg <= ST_STOP;
                        tx_reg    <= 1'b1;
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_reg <= '0;
                        if (pop) begin
                            data_reg  <= mem[rd_ptr_reg];
                            state_reg <= ST_START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= ST_IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ecall_console_tx.sv
// Scoreboarded bench for ecall_console_tx: stimulus queues expected frames, a UART-receiving monitor checks them.
module tb_ecall_console_tx;
    localparam int CPB = 4;
`ifdef CONSOLE_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (10 + PB) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       putc_valid = 1'b0;
    logic [7:0] putc_char = 8'h00;
    logic       putc_ready;
    logic       halt_req = 1'b0;
    logic       halt_done;
    logic       uart_tx;
    logic       busy;
    logic [3:0] fifo_count;

    ecall_console_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .putc_valid (putc_valid),
        .putc_char  (putc_char),
        .putc_ready (putc_ready),
        .halt_req   (halt_req),
        .halt_done  (halt_done),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [8:0] exp_q[$];   // {parity, data}
    int         start_q[$];

    task automatic chk(input string nm, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
        end
    endtask

    // UART receiver: samples mid-bit on falling edges, aborts an in-flight frame on reset.
    int         cyc = 0;
    bit         mon_active = 0;
    int         mon_t = 0;
    int         bi;
    logic [7:0] rx_data;
    logic       rx_par;
    logic [8:0] e;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (uart_tx == 1'b0) begin
                mon_active = 1;
                mon_t = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_t++;
        end
        if (mon_active && (mon_t % CPB) == CPB / 2) begin
            bi = mon_t / CPB;
            if (bi == 0) begin
                chk("start_bit", int'(uart_tx), 0);
            end else if (bi <= 8) begin
                rx_data[bi-1] = uart_tx;
            end else if (PB == 1 && bi == 9) begin
                rx_par = uart_tx;
            end else begin
                chk("stop_bit", int'(uart_tx), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", int'(rx_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_data", int'(rx_data), int'(e[7:0]));
                    if (PB == 1) chk("frame_parity", int'(rx_par), int'(e[8]));
                end
                mon_active = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        chk(nm, int'(n < limit), 1);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        step();
        chk({nm, "_tx"}, int'(uart_tx), 1);
        chk({nm, "_count"}, int'(fifo_count), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_halt_done"}, int'(halt_done), 0);
        chk({nm, "_ready"}, int'(putc_ready), 1);
        rst = 1'b0;
    endtask

    task automatic halt_drain(input string nm);
        int n;
        bit early;
        n = 0;
        early = 0;
        while (busy && n < 40 * FRAME) begin
            if (halt_done) early = 1;
            step();
            n++;
        end
        chk({nm, "_drain_in_time"}, int'(n < 40 * FRAME), 1);
        chk({nm, "_halt_done_early"}, int'(early), 0);
        chk({nm, "_halt_done_at_idle"}, int'(halt_done), 0);
        step();
        chk({nm, "_halt_done"}, int'(halt_done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", int'(uart_tx), 1);
        chk("reset_ready", int'(putc_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_halt_done", int'(halt_done), 0);
        chk("reset_count", int'(fifo_count), 0);
        rst = 1'b0;
        step();

        // Single char 0x41: exact latency and frame length
        chk("t1_ready", int'(putc_ready), 1);
        putc_valid = 1'b1;
        putc_char  = 8'h41;
        exp_q.push_back({1'b0, 8'h41});
        step();
        putc_valid = 1'b0;
        chk("t1_count_after_push", int'(fifo_count), 1);
        step();
        chk("t1_start_tx", int'(uart_tx), 0);
        chk("t1_popped", int'(fifo_count), 0);
        chk("t1_busy", int'(busy), 1);
        repeat (FRAME - 1) step();
        chk("t1_stop_tx", int'(uart_tx), 1);
        chk("t1_busy_last", int'(busy), 1);
        step();
        chk("t1_idle_tx", int'(uart_tx), 1);
        chk("t1_idle_busy", int'(busy), 0);

        // 0x07 carries odd popcount: parity bit 1 when enabled
        putc_valid = 1'b1;
        putc_char  = 8'h07;
        exp_q.push_back({1'b1, 8'h07});
        step();
        putc_valid = 1'b0;
        wait_idle("t1b_drain", 3 * FRAME);

        // Back-to-back fill: 9 accepted, continuous frames
        start_q.delete();
        putc_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            putc_char = 8'h30 + 8'(i);
            chk($sformatf("t2_ready_%0d", i), int'(putc_ready), int'(i <= 8));
            if (i <= 8) exp_q.push_back({^putc_char, putc_char});
            step();
        end
        putc_valid = 1'b0;
        chk("t2_count_full", int'(fifo_count), 8);
        wait_idle("t2_drain", 12 * FRAME);
        step();
        chk("t2_frames", start_q.size(), 9);
        for (int i = 1; i < start_q.size(); i++) begin
            chk($sformatf("t2_gap_%0d", i), start_q[i] - start_q[i-1], FRAME);
        end
        chk("t2_queue_empty", exp_q.size(), 0);

        // Halt drain after 'A','B'
        putc_valid = 1'b1;
        putc_char  = 8'h41;
        exp_q.push_back({1'b0, 8'h41});
        step();
        putc_char  = 8'h42;
        exp_q.push_back({1'b0, 8'h42});
        step();
        putc_valid = 1'b0;
        halt_req   = 1'b1;
        step();
        halt_req   = 1'b0;
        chk("t3_ready_low", int'(putc_ready), 0);
        chk("t3_halt_done_low", int'(halt_done), 0);
        halt_drain("t3");
        putc_valid = 1'b1;
        putc_char  = 8'h55;
        repeat (5) step();
        chk("t3_ready_after_halt", int'(putc_ready), 0);
        putc_valid = 1'b0;
        halt_req   = 1'b1;
        step();
        halt_req   = 1'b0;
        repeat (FRAME) step();
        chk("t3_count_ignored", int'(fifo_count), 0);
        chk("t3_busy_ignored", int'(busy), 0);
        chk("t3_halt_done_sticky", int'(halt_done), 1);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Simultaneous halt_req and push of 0x5A
        do_reset("t4_reset");
        chk("t4_ready", int'(putc_ready), 1);
        putc_valid = 1'b1;
        putc_char  = 8'h5A;
        halt_req   = 1'b1;
        exp_q.push_back({1'b0, 8'h5A});
        step();
        putc_valid = 1'b0;
        halt_req   = 1'b0;
        chk("t4_accepted", int'(fifo_count), 1);
        chk("t4_ready_low", int'(putc_ready), 0);
        halt_drain("t4");
        chk("t4_queue_empty", exp_q.size(), 0);

        // Reset mid-frame during data bit 3
        do_reset("t5_pre_reset");
        putc_valid = 1'b1;
        putc_char  = 8'hC3;
        step();
        putc_char  = 8'h3C;
        step();
        putc_valid = 1'b0;
        chk("t5_count_before", int'(fifo_count), 1);
        repeat (16) step();
        do_reset("t5_mid_reset");
        step();
        chk("t5_tx_after", int'(uart_tx), 1);
        putc_valid = 1'b1;
        putc_char  = 8'h96;
        exp_q.push_back({1'b0, 8'h96});
        step();
        putc_valid = 1'b0;
        step();
        chk("t5_clean_start", int'(uart_tx), 0);
        wait_idle("t5_drain", 3 * FRAME);
        step();
        chk("t5_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
